wb_dest_sequencer: RTL
======================

Name: wb_dest_sequencer

Overview:
- Write-side counterpart of the register-read selection logic. It decides which register-file entry an instruction's result is written to: accumulator, frame base, or the register encoded in the instruction.
- Sequences the register-file write port. ALU results are written after one cycle. Load results are held pending until memory returns data.
- Raises a stall to the fetch/decode stage on a read-after-pending-write hazard, or when a second writeback arrives while a load is outstanding.

Parameters:
- DATA_W, 8, width of register data.
- MEM_TIMEOUT, 15, maximum cycles to wait in WAIT_MEM for mem_valid before flagging an error.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wb_sel  input  2  destination select: 0 accumulator (reg 15), 1 frame base (reg 13), 2 {1'b0, instr[5:3]}, 3 no writeback
- instr  input  9  current instruction word
- wr_req  input  1  instruction retiring this cycle requests writeback
- is_load  input  1  qualifies wr_req: result comes from memory, not wr_data
- wr_data  input  DATA_W  ALU result for immediate writeback
- mem_valid  input  1  memory read data valid (one-cycle pulse)
- mem_data  input  DATA_W  memory read data
- rd_addr  input  4  register currently being read by decode (reg1 address)
- err_clr  input  1  clears sticky err
- rf_we  output  1  register-file write enable
- rf_waddr  output  4  register-file write address
- rf_wdata  output  DATA_W  register-file write data
- stall  output  1  hold fetch/decode this cycle (combinational)
- busy  output  1  load outstanding (state == WAIT_MEM)
- err  output  1  sticky: memory timeout occurred

Behaviour:
- Reset (rst_n low, async): state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, err=0, pending addr=0, timeout counter=0. busy=0 and stall=0 follow from the state.
- Address decode (combinational): 0→4'hF, 1→4'hD, 2→{1'b0,instr[5:3]}, 3→no write. A request with wb_sel=3 is accepted and produces no write.
- rf_we, rf_waddr and rf_wdata are registered. rf_we is a single-cycle pulse, and addr/data are held when rf_we=0.
- States: IDLE, WAIT_MEM.
- IDLE:
  - wr_req & !is_load & wb_sel!=3: next cycle rf_we=1, rf_waddr=decoded addr, rf_wdata=wr_data. Latency is 1 cycle.
  - wr_req & is_load & wb_sel!=3: latch decoded addr into pending, clear counter, go to WAIT_MEM. No write this cycle.
  - mem_valid in IDLE is ignored.
- WAIT_MEM:
  - mem_valid: next cycle rf_we=1, rf_waddr=pending, rf_wdata=mem_data; state goes to IDLE.
  - Otherwise the counter increments. When the counter reaches MEM_TIMEOUT-1 with no mem_valid: set err=1, go to IDLE, no write. A mem_valid on that same cycle wins and the write happens.
- stall = (state==WAIT_MEM) & (wr_req | (rd_addr==pending)). This includes the cycle mem_valid arrives; stall drops the following cycle.
- A wr_req raised while stall=1 is not accepted. The requester holds it until stall=0.
- Only one outstanding load is allowed; there is no forwarding of mem_data to readers.
- err_clr clears err. If a timeout fires in the same cycle as err_clr, err is set (set wins).
- Reset mid-load drops the pending write; no rf_we is issued afterwards.
- Counter width is $clog2(MEM_TIMEOUT+1) and it saturates rather than wrapping.

Decomposition:
- Shared package tinyarch_pkg holds:
  - wb_sel_e enum: WB_ACC=0, WB_FB=1, WB_INSTR=2, WB_NONE=3.
  - Constants REG_ACC=4'hF and REG_FB=4'hD, also used by the read-side selector.
  - Local state enum wbs_state_e: IDLE, WAIT_MEM.
- One sub-module: wb_addr_decode, combinational (wb_sel, instr → waddr, wvalid), instantiated once.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → all outputs 0 immediately. Release, then wr_req with wb_sel=0, wr_data=8'h5A → next cycle rf_we=1, rf_waddr=4'hF, rf_wdata=8'h5A, pulse lasts 1 cycle.
- Instruction-encoded destination: wb_sel=2, instr=9'b000_101_000, wr_data=8'h33 → rf_waddr=4'h5, rf_wdata=8'h33. With wb_sel=1 → rf_waddr=4'hD. With wb_sel=3 → no rf_we.
- Load with hazard: load with wb_sel=2, instr[5:3]=3; rd_addr=3 for 4 cycles → busy=1, stall=1 throughout. mem_valid with mem_data=8'hC4 on cycle 4 → next cycle rf_we=1, rf_waddr=4'h3, rf_wdata=8'hC4, stall=0. Rerun with rd_addr=7 and no wr_req → stall=0 during the wait.
- Back-to-back: a load followed by wr_req (ALU, wb_sel=0) during WAIT_MEM → stall=1 until mem_valid. The load write issues first; the ALU write issues the cycle after the request is accepted. Exactly two rf_we pulses, in order.
- Timeout: load with no mem_valid for MEM_TIMEOUT cycles → err=1, busy=0, no rf_we. A later mem_valid is ignored. err_clr=1 → err=0. Same-cycle timeout+err_clr → err=1.
- Reset mid-load: assert rst_n=0 while in WAIT_MEM, release, then pulse mem_valid → no rf_we, busy=0.

Source files
------------

// File: rtl/tinyarch_pkg.sv
// Shared definitions for the tiny-arch register-file read/write selection logic.
package tinyarch_pkg;

  typedef enum logic [1:0] {
    WB_ACC   = 2'd0,
    WB_FB    = 2'd1,
    WB_INSTR = 2'd2,
    WB_NONE  = 2'd3
  } wb_sel_e;

  localparam logic [3:0] REG_ACC = 4'hF;
  localparam logic [3:0] REG_FB  = 4'hD;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wbs_state_e;

endpackage

// File: rtl/wb_addr_decode.sv
// Maps a writeback select plus instruction word to a register-file write address.
module wb_addr_decode
  import tinyarch_pkg::*;
(
  input  logic [1:0] wb_sel,
  input  logic [8:0] instr,
  output logic [3:0] waddr,
  output logic       wvalid
);

  // Only instr[5:3] carries a register number on the write side.
  logic unused_instr;
  assign unused_instr = ^{instr[8:6], instr[2:0]};

  always_comb begin
    waddr  = 4'h0;
    wvalid = 1'b1;
    case (wb_sel_e'(wb_sel))
      WB_ACC:   waddr = REG_ACC;
      WB_FB:    waddr = REG_FB;
      WB_INSTR: waddr = {1'b0, instr[5:3]};
      WB_NONE:  wvalid = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_dest_sequencer.sv
// Sequences the register-file write port: one-cycle ALU writebacks, pending load
// writebacks with a memory timeout, and the decode stall for pending-write hazards.
module wb_dest_sequencer
  import tinyarch_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        wb_sel,
  input  logic [8:0]        instr,
  input  logic              wr_req,
  input  logic              is_load,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [3:0]        rd_addr,
  input  logic              err_clr,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall,
  output logic              busy,
  output logic              err
);

  localparam int unsigned    CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  wbs_state_e        state_q, state_d;
  logic [3:0]        pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [3:0]        waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              timeout;

  logic [3:0] dec_addr;
  logic       dec_valid;

  wb_addr_decode u_decode (
    .wb_sel (wb_sel),
    .instr  (instr),
    .waddr  (dec_addr),
    .wvalid (dec_valid)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req && dec_valid) begin
          if (is_load) begin
            pend_d  = dec_addr;
            cnt_d   = '0;
            state_d = WAIT_MEM;
          end else begin
            we_d    = 1'b1;
            waddr_d = dec_addr;
            wdata_d = wr_data;
          end
        end
      end
      WAIT_MEM: begin
        // Requests here are always stalled, so wr_req is never accepted.
        if (mem_valid) begin
          we_d    = 1'b1;
          waddr_d = pend_q;
          wdata_d = mem_data;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    err_d = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 4'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 4'h0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy     = (state_q == WAIT_MEM);
  assign stall    = busy && (wr_req || (rd_addr == pend_q));
  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign err      = err_q;

endmodule
